// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner and instruction-memory fetch handshake with misaligned-target fault detection
module instr_fetch_unit #(
    parameter int               Width    = 32,
    parameter logic [Width-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [Width-1:0] imem_addr,
    input  logic [Width-1:0] imem_rdata,
    input  logic             imem_ack,
    output logic [Width-1:0] instr,
    output logic             instr_valid,
    input  logic             instr_ready,
    input  logic [1:0]       PCsrc,
    input  logic [Width-1:0] ImmExt,
    input  logic [Width-1:0] ALUResult,
    output logic [Width-1:0] PC,
    output logic [Width-1:0] PCPlus4,
    output logic [31:0]      instret,
    output logic             fault,
    output logic [Width-1:0] fault_addr
);
    typedef enum logic [1:0] {BOOT, REQ, HOLD, FAULT} state_t;
    state_t           state_q, state_d;
    logic [Width-1:0] pc_q, pc_d, instr_q, instr_d, fault_addr_q, fault_addr_d, target;
    logic [31:0]      instret_q, instret_d;
    logic             fault_q, fault_d, commit, misaligned, alu_lsb_unused;
    assign alu_lsb_unused = ALUResult[0];
    assign imem_req    = state_q == REQ;
    assign imem_addr   = pc_q;
    assign instr_valid = state_q == HOLD;
    assign instr       = instr_q;
    assign PC          = pc_q;
    assign PCPlus4     = pc_q + Width'(4);
    assign instret     = instret_q;
    assign fault       = fault_q;
    assign fault_addr  = fault_addr_q;
    always_comb begin
        commit     = state_q == HOLD && instr_ready;
        // jalr clears the LSB before the alignment check, so only bit 1 can fault there
        target     = PCsrc == 2'b01 ? pc_q + ImmExt :
                     PCsrc == 2'b11 ? {ALUResult[Width-1:1], 1'b0} : pc_q + Width'(4);
        misaligned = |target[1:0];
        state_d    = state_q;
        case (state_q)
            BOOT:    state_d = REQ;
            REQ:     state_d = imem_ack ? HOLD : REQ;
            HOLD:    state_d = !instr_ready ? HOLD : misaligned ? FAULT : REQ;
            default: state_d = FAULT;
        endcase
        pc_d         = commit && !misaligned ? target : pc_q;
        instr_d      = state_q == REQ && imem_ack ? imem_rdata : instr_q;
        instret_d    = instret_q + 32'(commit);
        fault_d      = fault_q | (commit & misaligned);
        fault_addr_d = commit && misaligned ? target : fault_addr_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= BOOT;
            pc_q         <= RESET_PC;
            instr_q      <= Width'(32'h0000_0013);
            instret_q    <= '0;
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            instret_q    <= instret_d;
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
        end
    end
endmodule
